trap_ctrl: RTL and testbench
============================

# trap_ctrl

Trap sequencer owning the single write port of the machine-mode CSR file. Accepts ecall/exception and mret requests from the core, performs the multi-cycle read-modify-write of mstatus plus mepc/mcause updates, then issues a one-cycle PC redirect. Between traps it passes the core's Zicsr instruction accesses straight through to the CSR file, and stalls them while a sequence is in flight.

## Interface
- No parameters.
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- trap_valid / trap_ready  in/out  1  trap request handshake
- trap_pc  in  32  PC of the trapping instruction
- trap_cause  in  32  mcause value, e.g. 0x8 or 0xB for ecall
- trap_tval  in  32  mtval value; used only with the mtval macro
- mret_valid / mret_ready  in/out  1  mret request handshake
- inst_csr_wen, inst_csr_addr[11:0], inst_csr_wdata[31:0]  in  core Zicsr access
- inst_csr_rdata  out  32  read data returned to the core
- inst_csr_stall  out  1  core must hold its CSR access
- csr_wen, csr_addr[11:0], csr_wdata[31:0]  out  CSR file port
- csr_rdata, csr_mtvec, csr_mepc  in  32  CSR file outputs
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  32  redirect target
- The CSR file's built-in ecall shortcut input is tied low when this block is instantiated.

## Operation
- States: IDLE, RD_MST, WR_MEPC, WR_MCAUSE, WR_MTVAL (macro only), WR_MST, REDIRECT.
- IDLE behaviour:
  - csr_* = inst_csr_* (pass-through).
  - inst_csr_rdata = csr_rdata.
  - trap_ready = ~inst_csr_wen.
  - mret_ready = ~inst_csr_wen & ~trap_valid. Trap wins over mret.
- On acceptance:
  - Trap: latch trap_pc, trap_cause and trap_tval; set the op flag to TRAP; go to RD_MST.
  - Mret: set the op flag to MRET; go to RD_MST.
- RD_MST: csr_addr=0x300, csr_wen=0; latch csr_rdata into mst_q.
- WR_MEPC: write 0x341 with the latched pc, bits [1:0] forced to 0.
- WR_MCAUSE: write 0x342 with the latched cause.
- WR_MTVAL: write 0x343 with the latched tval.
- WR_MST: write 0x300 with the updated mstatus value.
  - TRAP: MPIE(bit7) := MIE(bit3); MIE := 0; MPP[12:11] := 2'b11.
  - MRET: MIE := MPIE; MPIE := 1; MPP := 2'b11.
  - All other bits are preserved from mst_q.
- Path order:
  - TRAP: RD_MST → WR_MEPC → WR_MCAUSE → [WR_MTVAL] → WR_MST.
  - MRET: RD_MST → WR_MST.
- REDIRECT: redirect_valid=1 for one cycle, then go to IDLE.
  - TRAP target: {csr_mtvec[31:2],2'b00}.
  - MRET target: csr_mepc.
- Outside IDLE:
  - inst_csr_stall=1, trap_ready=0, mret_ready=0.
  - inst_csr_rdata=0. Core writes are ignored; the core holds them.

## Timing
- Reset (async assert, sync-free deassert): state=IDLE; latches, mst_q and the op flag cleared.
  - Outputs after reset: redirect_valid=0, redirect_pc=0, inst_csr_stall=0.
  - trap_ready=~inst_csr_wen; csr_* follow inst_csr_*.
- Trap latency (accept in cycle 0):
  - Without macro: RD 1, MEPC 2, MCAUSE 3, MST 4, redirect_valid in cycle 5, ready again cycle 6.
  - With macro: each step after MCAUSE shifts by +1.
- Mret latency: RD 1, MST 2, redirect_valid in cycle 3.
- Visibility: each CSR write is visible from the following cycle. csr_mtvec and csr_mepc are sampled in REDIRECT, so they reflect all writes made by the sequence.
- Write port use: exactly one write per write state; never two writes in one cycle.
- Reset mid-sequence: the sequence aborts with no redirect. CSR writes already made remain in the CSR file.
- Back-to-back requests: a request held asserted across REDIRECT is accepted in the next IDLE cycle.

## Configuration
- TRAP_CTRL_MTVAL_EN defined: the WR_MTVAL state exists and trap_tval is latched and written to 0x343.
- Undefined: trap_tval is ignored, there is no 0x343 write, and trap latency is 5 cycles.

## Structure
- trap_ctrl_pkg contains:
  - State encoding.
  - CSR address constants 0x300/0x305/0x341/0x342/0x343.
  - mstatus bit positions MIE=3, MPIE=7, MPP=12:11.
  - Cause constants ECALL_U=8, ECALL_M=11.
- One combinational sub-module, mstatus_upd (in: mst, is_mret; out: next mstatus), instantiated once.

## Test plan
- Trap: pc=0x80000104, cause=0xB, mstatus=0x8, mtvec=0x80000201.
  - Expected: writes mepc=0x80000104, mcause=0xB, mstatus=0x1880.
  - redirect_pc=0x80000200, redirect_valid in cycle 5.
- Mret after that trap: mstatus=0x1888 written; redirect_pc=0x80000104 in cycle 3.
- Simultaneous inst_csr_wen (addr 0x305, data 0x100) with trap_valid: the inst write passes through and trap_ready=0. The trap is accepted the next cycle; redirect_pc=0x100.
- Simultaneous trap_valid and mret_valid: trap accepted, mret_ready=0 until trap completes.
- rst_n low in WR_MCAUSE: state IDLE immediately; no redirect_valid; mepc keeps the new value.
- TRAP_CTRL_MTVAL_EN, tval=0xDEAD: 0x343 written in cycle 4; redirect in cycle 6.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// ============================================================================
// Module  : trap_ctrl_pkg
// Purpose : State encoding, CSR addresses and mstatus fields for trap_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package trap_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_MST    = 3'd1,
    ST_WR_MEPC   = 3'd2,
    ST_WR_MCAUSE = 3'd3,
    ST_WR_MTVAL  = 3'd4,
    ST_WR_MST    = 3'd5,
    ST_REDIRECT  = 3'd6
  } state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MST_MIE    = 3;
  localparam int MST_MPIE   = 7;
  localparam int MST_MPP_LO = 11;
  localparam int MST_MPP_HI = 12;

  localparam logic [31:0] CAUSE_ECALL_U = 32'd8;
  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

  function automatic logic is_ecall(input logic [31:0] cause);
    return (cause == CAUSE_ECALL_U) || (cause == CAUSE_ECALL_M);
  endfunction

  function automatic logic is_trap_csr(input logic [11:0] addr);
    return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) || (addr == CSR_MEPC) ||
           (addr == CSR_MCAUSE)  || (addr == CSR_MTVAL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/trap_ctrl_mstatus_upd.sv
// ============================================================================
// Module  : mstatus_upd
// Purpose : Next mstatus value for trap entry (is_mret=0) or mret (is_mret=1).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mstatus_upd
  import trap_ctrl_pkg::*;
(
  input  logic [31:0] mst_i,
  input  logic        is_mret_i,
  output logic [31:0] mst_o
);

  always_comb begin
    mst_o = mst_i;
    mst_o[MST_MPP_HI:MST_MPP_LO] = 2'b11;
    if (is_mret_i) begin
      mst_o[MST_MIE]  = mst_i[MST_MPIE];
      mst_o[MST_MPIE] = 1'b1;
    end else begin
      mst_o[MST_MPIE] = mst_i[MST_MIE];
      mst_o[MST_MIE]  = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/trap_ctrl.sv
// ============================================================================
// Module  : trap_ctrl
// Purpose : Trap/mret sequencer owning the M-mode CSR write port; Zicsr
//           accesses pass through while idle. Option: TRAP_CTRL_MTVAL_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        trap_valid_i,
  output logic        trap_ready_o,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_cause_i,
  input  logic [31:0] trap_tval_i,
  input  logic        mret_valid_i,
  output logic        mret_ready_o,
  input  logic        inst_csr_wen_i,
  input  logic [11:0] inst_csr_addr_i,
  input  logic [31:0] inst_csr_wdata_i,
  output logic [31:0] inst_csr_rdata_o,
  output logic        inst_csr_stall_o,
  output logic        csr_wen_o,
  output logic [11:0] csr_addr_o,
  output logic [31:0] csr_wdata_o,
  input  logic [31:0] csr_rdata_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] cause_q;
  logic [31:0] mst_q;
  logic        is_mret_q;
  logic [31:0] w_mst_next;
  logic        w_idle;

`ifdef TRAP_CTRL_MTVAL_EN
  logic [31:0] tval_q;
`else
  logic        w_unused_tval;
  assign w_unused_tval = ^trap_tval_i;
`endif

  // mtvec mode bits never influence the direct-mode target.
  logic w_unused_mtvec;
  assign w_unused_mtvec = ^csr_mtvec_i[1:0];

  assign w_idle       = (state_q == ST_IDLE);
  assign trap_ready_o = w_idle & ~inst_csr_wen_i;
  assign mret_ready_o = w_idle & ~inst_csr_wen_i & ~trap_valid_i;

  mstatus_upd u_mstatus_upd (
    .mst_i     (mst_q),
    .is_mret_i (is_mret_q),
    .mst_o     (w_mst_next)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      cause_q   <= '0;
      mst_q     <= '0;
      is_mret_q <= 1'b0;
`ifdef TRAP_CTRL_MTVAL_EN
      tval_q    <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (trap_valid_i && trap_ready_o) begin
            pc_q      <= trap_pc_i;
            cause_q   <= trap_cause_i;
`ifdef TRAP_CTRL_MTVAL_EN
            tval_q    <= trap_tval_i;
`endif
            is_mret_q <= 1'b0;
            state_q   <= ST_RD_MST;
          end else if (mret_valid_i && mret_ready_o) begin
            is_mret_q <= 1'b1;
            state_q   <= ST_RD_MST;
          end
        end
        ST_RD_MST: begin
          mst_q   <= csr_rdata_i;
          state_q <= is_mret_q ? ST_WR_MST : ST_WR_MEPC;
        end
        ST_WR_MEPC:   state_q <= ST_WR_MCAUSE;
`ifdef TRAP_CTRL_MTVAL_EN
        ST_WR_MCAUSE: state_q <= ST_WR_MTVAL;
        ST_WR_MTVAL:  state_q <= ST_WR_MST;
`else
        ST_WR_MCAUSE: state_q <= ST_WR_MST;
`endif
        ST_WR_MST:    state_q <= ST_REDIRECT;
        ST_REDIRECT:  state_q <= ST_IDLE;
        default:      state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    csr_wen_o        = 1'b0;
    csr_addr_o       = 12'h000;
    csr_wdata_o      = 32'h0;
    inst_csr_rdata_o = 32'h0;
    inst_csr_stall_o = 1'b1;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = 32'h0;
    case (state_q)
      ST_IDLE: begin
        csr_wen_o        = inst_csr_wen_i;
        csr_addr_o       = inst_csr_addr_i;
        csr_wdata_o      = inst_csr_wdata_i;
        inst_csr_rdata_o = csr_rdata_i;
        inst_csr_stall_o = 1'b0;
      end
      ST_RD_MST: csr_addr_o = CSR_MSTATUS;
      ST_WR_MEPC: begin
        csr_wen_o   = 1'b1;
        csr_addr_o  = CSR_MEPC;
        csr_wdata_o = {pc_q[31:2], 2'b00};
      end
      ST_WR_MCAUSE: begin
        csr_wen_o   = 1'b1;
        csr_addr_o  = CSR_MCAUSE;
        csr_wdata_o = cause_q;
      end
`ifdef TRAP_CTRL_MTVAL_EN
      ST_WR_MTVAL: begin
        csr_wen_o   = 1'b1;
        csr_addr_o  = CSR_MTVAL;
        csr_wdata_o = tval_q;
      end
`endif
      ST_WR_MST: begin
        csr_wen_o   = 1'b1;
        csr_addr_o  = CSR_MSTATUS;
        csr_wdata_o = w_mst_next;
      end
      ST_REDIRECT: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = is_mret_q ? csr_mepc_i : {csr_mtvec_i[31:2], 2'b00};
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// ============================================================================
// Module  : tb_trap_ctrl
// Purpose : Self-checking bench for trap_ctrl with a CSR-file stand-in and a
//           per-cycle expected-activity queue model. Honours TRAP_CTRL_MTVAL_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_trap_ctrl;

`ifdef TRAP_CTRL_MTVAL_EN
  localparam int TRAP_N  = 6;
  localparam int MTVAL_C = 4;
`else
  localparam int TRAP_N  = 5;
  localparam int MTVAL_C = -1;
`endif

  logic        clk, rst_n;
  logic        trap_valid, trap_ready, mret_valid, mret_ready;
  logic [31:0] trap_pc, trap_cause, trap_tval;
  logic        inst_wen, inst_stall;
  logic [11:0] inst_addr;
  logic [31:0] inst_wdata, inst_rdata;
  logic        csr_wen;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata, csr_mtvec, csr_mepc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_cmp = 0;
  int n_bad = 0;
  bit init_done = 0;

  trap_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .trap_valid_i(trap_valid), .trap_ready_o(trap_ready),
    .trap_pc_i(trap_pc), .trap_cause_i(trap_cause), .trap_tval_i(trap_tval),
    .mret_valid_i(mret_valid), .mret_ready_o(mret_ready),
    .inst_csr_wen_i(inst_wen), .inst_csr_addr_i(inst_addr),
    .inst_csr_wdata_i(inst_wdata), .inst_csr_rdata_o(inst_rdata),
    .inst_csr_stall_o(inst_stall),
    .csr_wen_o(csr_wen), .csr_addr_o(csr_addr), .csr_wdata_o(csr_wdata),
    .csr_rdata_i(csr_rdata), .csr_mtvec_i(csr_mtvec), .csr_mepc_i(csr_mepc),
    .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CSR file stand-in: only the five machine CSRs this block touches.
  logic [31:0] csrf [5];

  function automatic int cidx(input logic [11:0] a);
    case (a)
      12'h300: return 0;
      12'h305: return 1;
      12'h341: return 2;
      12'h342: return 3;
      12'h343: return 4;
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] crd(input logic [11:0] a);
    int i;
    i = cidx(a);
    return (i < 0) ? 32'h0 : csrf[i];
  endfunction

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 5; i++) csrf[i] <= 32'h0;
    end else if (csr_wen && cidx(csr_addr) >= 0) begin
      csrf[cidx(csr_addr)] <= csr_wdata;
    end
  end

  always_comb csr_rdata = crd(csr_addr);
  assign csr_mtvec = csrf[1];
  assign csr_mepc  = csrf[2];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        wen;
    logic        chka;
    logic [11:0] addr;
    logic [31:0] wd;
    logic        rv;
    logic [31:0] rpc;
  } step_t;

  step_t exp_q[$];

  function automatic step_t mk(input logic w, input logic ca, input logic [11:0] a,
                               input logic [31:0] d, input logic r, input logic [31:0] p);
    step_t s;
    s.wen = w; s.chka = ca; s.addr = a; s.wd = d; s.rv = r; s.rpc = p;
    return s;
  endfunction

  always @(negedge clk) begin
    logic [112:0] act, exp;
    logic [31:0]  m, nm;
    step_t        s;
    if (!rst_n) exp_q.delete();
    if (exp_q.size() > 0) begin
      s   = exp_q.pop_front();
      act = {csr_wen, s.chka ? csr_addr : 12'h0, csr_wen ? csr_wdata : 32'h0,
             redirect_valid, redirect_valid ? redirect_pc : 32'h0,
             inst_stall, trap_ready, mret_ready, inst_rdata};
      exp = {s.wen, s.chka ? s.addr : 12'h0, s.wen ? s.wd : 32'h0,
             s.rv, s.rv ? s.rpc : 32'h0, 1'b1, 1'b0, 1'b0, 32'h0};
    end else begin
      act = {csr_wen, csr_addr, csr_wen ? csr_wdata : 32'h0,
             redirect_valid, redirect_valid ? redirect_pc : 32'h0,
             inst_stall, trap_ready, mret_ready, inst_rdata};
      exp = {inst_wen, inst_addr, inst_wen ? inst_wdata : 32'h0, 1'b0, 32'h0,
             1'b0, ~inst_wen, ~inst_wen & ~trap_valid, crd(inst_addr)};
      m = crd(12'h300);
      if (rst_n && !inst_wen && trap_valid) begin
        nm = (m & ~32'h1888) | 32'h1800 | (((m >> 3) & 32'h1) << 7);
        exp_q.push_back(mk(1'b0, 1'b1, 12'h300, 32'h0, 1'b0, 32'h0));
        exp_q.push_back(mk(1'b1, 1'b1, 12'h341, trap_pc & 32'hFFFF_FFFC, 1'b0, 32'h0));
        exp_q.push_back(mk(1'b1, 1'b1, 12'h342, trap_cause, 1'b0, 32'h0));
`ifdef TRAP_CTRL_MTVAL_EN
        exp_q.push_back(mk(1'b1, 1'b1, 12'h343, trap_tval, 1'b0, 32'h0));
`endif
        exp_q.push_back(mk(1'b1, 1'b1, 12'h300, nm, 1'b0, 32'h0));
        exp_q.push_back(mk(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, crd(12'h305) & 32'hFFFF_FFFC));
      end else if (rst_n && !inst_wen && mret_valid) begin
        nm = (m & ~32'h1888) | 32'h1880 | (((m >> 7) & 32'h1) << 3);
        exp_q.push_back(mk(1'b0, 1'b1, 12'h300, 32'h0, 1'b0, 32'h0));
        exp_q.push_back(mk(1'b1, 1'b1, 12'h300, nm, 1'b0, 32'h0));
        exp_q.push_back(mk(1'b0, 1'b0, 12'h0, 32'h0, 1'b1, crd(12'h341)));
      end
    end
    chk("cycle", {15'h0, act}, {15'h0, exp});
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    step();
    inst_wen = 1'b1; inst_addr = a; inst_wdata = d;
    step();
    inst_wen = 1'b0;
  endtask

  // Called one tick after the accepting edge; counts cycles 1..N from acceptance.
  task automatic run_seq(input string nm, input int exp_n, input logic [31:0] exp_pc,
                         input int exp_tv, input bit mret_low);
    int n_rv, n_tv;
    logic [31:0] pc;
    n_rv = -1; n_tv = -1; pc = 32'h0;
    for (int n = 1; n <= 20 && n_rv < 0; n++) begin
      @(negedge clk);
      if (mret_low) chk({nm, " mret_ready"}, {127'h0, mret_ready}, 128'h0);
      if (csr_wen && csr_addr == 12'h343) n_tv = n;
      if (redirect_valid) begin n_rv = n; pc = redirect_pc; end
    end
    chk({nm, " redirect cycle"}, n_rv, exp_n);
    chk({nm, " redirect pc"}, pc, exp_pc);
    chk({nm, " mtval cycle"}, n_tv, exp_tv);
  endtask

  initial begin
    int rv_seen;
    rst_n = 1'b0; trap_valid = 0; mret_valid = 0; inst_wen = 0;
    trap_pc = 0; trap_cause = 0; trap_tval = 0; inst_addr = 12'h305; inst_wdata = 0;
    repeat (3) step();
    chk("reset redirect_valid", {127'h0, redirect_valid}, 128'h0);
    chk("reset redirect_pc", redirect_pc, 32'h0);
    chk("reset stall", {127'h0, inst_stall}, 128'h0);
    chk("reset trap_ready", {127'h0, trap_ready}, 128'h1);
    init_done = 1;
    step();
    rst_n = 1'b1;

    // Trap entry from mstatus=0x8
    csr_write(12'h300, 32'h8);
    csr_write(12'h305, 32'h8000_0201);
    trap_valid = 1; trap_pc = 32'h8000_0104; trap_cause = 32'hB; trap_tval = 32'hDEAD;
    step();
    trap_valid = 0;
    run_seq("trap", TRAP_N, 32'h8000_0200, MTVAL_C, 1'b0);
    step();
    chk("trap mepc", csrf[2], 32'h8000_0104);
    chk("trap mcause", csrf[3], 32'hB);
    chk("trap mstatus", csrf[0], 32'h1880);
`ifdef TRAP_CTRL_MTVAL_EN
    chk("trap mtval", csrf[4], 32'hDEAD);
`else
    chk("trap mtval", csrf[4], 32'h0);
`endif

    // Mret back
    mret_valid = 1;
    step();
    mret_valid = 0;
    run_seq("mret", 3, 32'h8000_0104, -1, 1'b0);
    step();
    chk("mret mstatus", csrf[0], 32'h1888);

    // Core write collides with trap request
    inst_wen = 1; inst_addr = 12'h305; inst_wdata = 32'h100;
    trap_valid = 1; trap_pc = 32'h8000_0302; trap_cause = 32'h8;
    @(negedge clk);
    chk("collide trap_ready", {127'h0, trap_ready}, 128'h0);
    chk("collide csr_wen", {127'h0, csr_wen}, 128'h1);
    step();
    inst_wen = 0;
    @(negedge clk);
    chk("collide trap_ready next", {127'h0, trap_ready}, 128'h1);
    step();
    trap_valid = 0;
    run_seq("collide", TRAP_N, 32'h100, MTVAL_C, 1'b0);
    step();
    chk("collide mepc", csrf[2], 32'h8000_0300);
    chk("collide mtvec", csrf[1], 32'h100);

    // Trap and mret together: trap first, mret held across REDIRECT
    trap_valid = 1; mret_valid = 1; trap_pc = 32'h8000_0400; trap_cause = 32'hB;
    @(negedge clk);
    chk("both mret_ready", {127'h0, mret_ready}, 128'h0);
    step();
    trap_valid = 0;
    run_seq("both trap", TRAP_N, 32'h100, MTVAL_C, 1'b1);
    step();
    @(negedge clk);
    chk("both mret_ready idle", {127'h0, mret_ready}, 128'h1);
    step();
    mret_valid = 0;
    run_seq("both mret", 3, 32'h8000_0400, -1, 1'b0);
    step();
    chk("both mstatus", csrf[0], 32'h1880);

    // Reset during WR_MCAUSE
    trap_valid = 1; trap_pc = 32'h1234_5678; trap_cause = 32'h8;
    step();
    trap_valid = 0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("abort stall", {127'h0, inst_stall}, 128'h0);
    chk("abort trap_ready", {127'h0, trap_ready}, 128'h1);
    rv_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (redirect_valid) rv_seen++;
    end
    chk("abort no redirect", rv_seen, 0);
    step();
    rst_n = 1'b1;
    chk("abort mepc kept", csrf[2], 32'h1234_5678);
    chk("abort mcause old", csrf[3], 32'hB);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step();
      trap_valid = ($urandom_range(0, 3) == 0);
      mret_valid = ($urandom_range(0, 3) == 0);
      inst_wen   = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0: inst_addr = 12'h300;
        1: inst_addr = 12'h305;
        2: inst_addr = 12'h341;
        3: inst_addr = 12'h342;
        default: inst_addr = 12'h343;
      endcase
      inst_wdata = $urandom;
      trap_pc    = $urandom;
      trap_cause = ($urandom_range(0, 1) == 0) ? 32'h8 : 32'hB;
      trap_tval  = $urandom;
    end
    step();
    trap_valid = 0; mret_valid = 0; inst_wen = 0;
    repeat (12) step();
    @(negedge clk);
    chk("drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
